// File: rtl/bfly00_stage.sv
// First radix-2 DIF butterfly stage of the 512-point streaming FFT (16 lanes per beat).
// Beats 0..DEPTH-1 of each block are buffered; beats DEPTH..2*DEPTH-1 are combined with them.
module bfly00_stage #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    din_valid,
  input  logic signed [WIDTH-1:0] din_re           [0:15],
  input  logic signed [WIDTH-1:0] din_im           [0:15],
  output logic                    bfly00_valid,
  output logic signed [WIDTH:0]   o_00bfly_sum_re  [0:15],
  output logic signed [WIDTH:0]   o_00bfly_sum_im  [0:15],
  output logic signed [WIDTH:0]   o_00bfly_diff_re [0:15],
  output logic signed [WIDTH:0]   o_00bfly_diff_im [0:15],
  output logic                    o_fill
);

  // Handshake: a beat is consumed on every rising edge with din_valid=1 and rstn=0;
  // there is no back-pressure, and bfly00_valid is a one-cycle qualifier per result beat.

  localparam int LANES = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic {ST_FILL = 1'b0, ST_CALC = 1'b1} state_e;

  state_e          state;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx;
  logic            wr_en, calc_en;
  logic            valid_q;

  logic signed [WIDTH-1:0] mem_re_q [0:DEPTH-1][0:LANES-1];
  logic signed [WIDTH-1:0] mem_im_q [0:DEPTH-1][0:LANES-1];

  logic signed [WIDTH:0] sum_re_q  [0:LANES-1], sum_re_d  [0:LANES-1];
  logic signed [WIDTH:0] sum_im_q  [0:LANES-1], sum_im_d  [0:LANES-1];
  logic signed [WIDTH:0] diff_re_q [0:LANES-1], diff_re_d [0:LANES-1];
  logic signed [WIDTH:0] diff_im_q [0:LANES-1], diff_im_d [0:LANES-1];

  function automatic logic signed [WIDTH:0] ext(input logic signed [WIDTH-1:0] v);
    return {v[WIDTH-1], v};
  endfunction

  // State register: the phase lives entirely in the beat counter.
  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Next state: the counter width makes the 2*DEPTH-1 -> 0 wrap free.
  always_comb begin
    cnt_d = cnt_q;
    if (din_valid) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Outputs decoded from state.
  always_comb begin
    state   = cnt_q[CW-1] ? ST_CALC : ST_FILL;
    o_fill  = (state == ST_FILL);
    wr_en   = din_valid && !rstn && (state == ST_FILL);
    calc_en = din_valid && !rstn && (state == ST_CALC);
  end

  assign idx = cnt_q[AW-1:0];

  // Buffer is never cleared; stale contents are overwritten before they are read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < LANES; j++) begin
        mem_re_q[idx][j] <= din_re[j];
        mem_im_q[idx][j] <= din_im[j];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      sum_re_d[j]  = sum_re_q[j];
      sum_im_d[j]  = sum_im_q[j];
      diff_re_d[j] = diff_re_q[j];
      diff_im_d[j] = diff_im_q[j];
      if (calc_en) begin
        sum_re_d[j]  = ext(mem_re_q[idx][j]) + ext(din_re[j]);
        sum_im_d[j]  = ext(mem_im_q[idx][j]) + ext(din_im[j]);
        diff_re_d[j] = ext(mem_re_q[idx][j]) - ext(din_re[j]);
        diff_im_d[j] = ext(mem_im_q[idx][j]) - ext(din_im[j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      valid_q <= 1'b0;
      for (int j = 0; j < LANES; j++) begin
        sum_re_q[j]  <= '0;
        sum_im_q[j]  <= '0;
        diff_re_q[j] <= '0;
        diff_im_q[j] <= '0;
      end
    end else begin
      valid_q <= calc_en;
      for (int j = 0; j < LANES; j++) begin
        sum_re_q[j]  <= sum_re_d[j];
        sum_im_q[j]  <= sum_im_d[j];
        diff_re_q[j] <= diff_re_d[j];
        diff_im_q[j] <= diff_im_d[j];
      end
    end
  end

  assign bfly00_valid     = valid_q;
  assign o_00bfly_sum_re  = sum_re_q;
  assign o_00bfly_sum_im  = sum_im_q;
  assign o_00bfly_diff_re = diff_re_q;
  assign o_00bfly_diff_im = diff_im_q;

endmodule

// File: tb/tb_bfly00_stage.sv
// Directed bench for bfly00_stage: stimulus pushes hand-derived result beats into a queue,
// a negedge monitor pops and compares whenever bfly00_valid is seen.
module tb_bfly00_stage;

  localparam int W  = 10 * 64;   // 4 components x 16 lanes x 10 bits per result beat
  localparam int NEXP = 116;     // 16+16+16+32+4+16+16 result beats over the whole run

  // Clock / reset block
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic din_valid = 1'b0;
  logic signed [8:0] din_re [0:15];
  logic signed [8:0] din_im [0:15];
  logic bfly00_valid;
  logic signed [9:0] sum_re [0:15];
  logic signed [9:0] sum_im [0:15];
  logic signed [9:0] diff_re [0:15];
  logic signed [9:0] diff_im [0:15];
  logic o_fill;

  always #5 clk = ~clk;

  bfly00_stage #(.WIDTH(9), .DEPTH(16)) dut (
    .clk(clk),
    .rstn(rstn),
    .din_valid(din_valid),
    .din_re(din_re),
    .din_im(din_im),
    .bfly00_valid(bfly00_valid),
    .o_00bfly_sum_re(sum_re),
    .o_00bfly_sum_im(sum_im),
    .o_00bfly_diff_re(diff_re),
    .o_00bfly_diff_im(diff_im),
    .o_fill(o_fill)
  );

  int total = 0;
  int bad = 0;
  int n_valid = 0;
  logic [W-1:0] exp_q[$];

  // Stimulus modes: 0 = ramp, 1 = extremes, 2 = negated ramp
  function automatic int stim_re(input int mode, input int b, input int j);
    case (mode)
      0:       return b * 16 + j - 256;
      1:       return (b < 16) ? -256 : 255;
      default: return -(b * 16 + j - 256);
    endcase
  endfunction

  function automatic int stim_im(input int mode, input int b);
    if (mode == 1) return (b < 16) ? -256 : 255;
    return 0;
  endfunction

  // Hand-derived result beat k of a block.
  function automatic logic [W-1:0] exp_beat(input int mode, input int k);
    logic [W-1:0] v;
    int m, sr, si, dr, di;
    v = '0;
    for (int j = 0; j < 16; j++) begin
      m = k * 16 + j;
      case (mode)
        0: begin sr = 2 * m - 256; si = 0; dr = -256; di = 0; end
        1: begin sr = -1; si = -1; dr = -511; di = -511; end
        default: begin
          // -(-256) does not fit 9 bits and wraps back to -256 on lane 0 of beat 0
          if (m == 0) begin sr = -256; dr = -256; end
          else begin sr = 256 - 2 * m; dr = 256; end
          si = 0; di = 0;
        end
      endcase
      v[(0 * 16 + j) * 10 +: 10] = 10'(sr);
      v[(1 * 16 + j) * 10 +: 10] = 10'(si);
      v[(2 * 16 + j) * 10 +: 10] = 10'(dr);
      v[(3 * 16 + j) * 10 +: 10] = 10'(di);
    end
    return v;
  endfunction

  function automatic logic [W-1:0] dut_beat();
    logic [W-1:0] v;
    for (int j = 0; j < 16; j++) begin
      v[(0 * 16 + j) * 10 +: 10] = sum_re[j];
      v[(1 * 16 + j) * 10 +: 10] = sum_im[j];
      v[(2 * 16 + j) * 10 +: 10] = diff_re[j];
      v[(3 * 16 + j) * 10 +: 10] = diff_im[j];
    end
    return v;
  endfunction

  // Driver tasks
  task automatic send_beat(input int mode, input int b);
    @(posedge clk);
    #1;
    total++;
    if (o_fill !== (b < 16)) begin
      bad++;
      $display("FAIL o_fill beat=%0d got=%b exp=%b", b, o_fill, (b < 16));
    end
    din_valid = 1'b1;
    for (int j = 0; j < 16; j++) begin
      din_re[j] = 9'(stim_re(mode, b, j));
      din_im[j] = 9'(stim_im(mode, b));
    end
    if (b >= 16) exp_q.push_back(exp_beat(mode, b - 16));
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic send_block(input int mode, input int nbeats, input bit gapped);
    for (int b = 0; b < nbeats; b++) begin
      send_beat(mode, b);
      if (gapped) idle();
    end
  endtask

  task automatic do_reset(input bit with_valid);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    din_valid = with_valid;
    for (int j = 0; j < 16; j++) begin
      din_re[j] = 9'sd77;
      din_im[j] = -9'sd33;
    end
    @(posedge clk);
    #1;
    rstn = 1'b0;
    din_valid = 1'b0;
  endtask

  // Scoreboard monitor
  logic rst_at_edge = 1'b1;
  logic [W-1:0] last_beat = '0;
  always @(posedge clk) rst_at_edge <= rstn;

  always @(negedge clk) begin
    if (rst_at_edge) begin
      total++;
      if (bfly00_valid !== 1'b0 || dut_beat() !== '0 || o_fill !== 1'b1) begin
        bad++;
        $display("FAIL reset_state valid=%b fill=%b out=%h", bfly00_valid, o_fill, dut_beat());
      end
      last_beat = '0;
    end else if (bfly00_valid === 1'b1) begin
      n_valid++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid got=%h", dut_beat());
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (dut_beat() !== e) begin
          bad++;
          $display("FAIL result_%0d got=%h exp=%h", n_valid, dut_beat(), e);
        end
      end
      last_beat = dut_beat();
    end else begin
      total++;
      if (bfly00_valid !== 1'b0 || dut_beat() !== last_beat) begin
        bad++;
        $display("FAIL hold valid=%b got=%h exp=%h", bfly00_valid, dut_beat(), last_beat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < 16; j++) begin
      din_re[j] = '0;
      din_im[j] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;

    send_block(0, 32, 1'b0);   // contiguous ramp
    idle();
    send_block(1, 32, 1'b0);   // extremes
    idle();
    send_block(0, 32, 1'b1);   // gapped ramp
    idle();
    send_block(0, 32, 1'b0);   // back-to-back: ramp then negated ramp
    send_block(2, 32, 1'b0);
    idle();
    send_block(0, 20, 1'b0);   // partial block interrupted by reset
    do_reset(1'b0);
    send_block(0, 32, 1'b0);
    idle();
    do_reset(1'b1);            // reset coincident with a valid beat
    send_block(0, 32, 1'b0);
    idle();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    total++;
    if (n_valid != NEXP) begin
      bad++;
      $display("FAIL valid_count got=%0d exp=%0d", n_valid, NEXP);
    end
    total++;
    if (o_fill !== 1'b1) begin
      bad++;
      $display("FAIL final_fill got=%b exp=1", o_fill);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bfly00_stage.md
Name: bfly00_stage

Overview:
- First radix-2 DIF butterfly stage of the 512-point streaming FFT, 16 complex lanes per clock.
- One 512-sample block arrives over 32 valid beats. Beats 0..15 carry x[0..255] and are buffered. Beats 16..31 carry x[256..511] and are combined lane-by-lane with the buffered beat to produce sum and difference.
- Drives the stage-00 twiddle multiplier directly: bfly00_valid feeds its twd00_valid, and the four 16-lane result arrays feed its sum/diff inputs.

Parameters:
- WIDTH, 9, input sample width (signed <3.6>); outputs are WIDTH+1 bits (<4.6>).
- DEPTH, 16, beats per half-block; this is the buffer depth and must be a power of 2.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous reset, active-high (1 = reset), sampled on rising clk.
- din_valid  input  1  input beat qualifier; one beat = 16 lanes.
- din_re[0:15]  input  WIDTH each, signed  real part, lane j = sample beat*16+j of the current half.
- din_im[0:15]  input  WIDTH each, signed  imaginary part.
- bfly00_valid  output  1  result beat valid.
- o_00bfly_sum_re[0:15]  output  WIDTH+1 each, signed  buf_re + din_re.
- o_00bfly_sum_im[0:15]  output  WIDTH+1 each, signed  buf_im + din_im.
- o_00bfly_diff_re[0:15]  output  WIDTH+1 each, signed  buf_re - din_re.
- o_00bfly_diff_im[0:15]  output  WIDTH+1 each, signed  buf_im - din_im.
- o_fill  output  1  high while the block is in the FILL phase.

Behaviour:
- Reset (rstn=1 at a clock edge): beat counter = 0, state = FILL, bfly00_valid = 0, all result outputs = 0, o_fill = 1. Buffer contents are don't-care and are not cleared.
- Beat counter:
  - 5 bits, range 0..2*DEPTH-1.
  - Increments only on a clock edge with din_valid=1.
  - Wraps 31 -> 0, so back-to-back blocks need no idle cycle.
  - State is derived from the counter: FILL when cnt < DEPTH, CALC otherwise. o_fill = (state==FILL), combinational from the counter.
- FILL, din_valid=1: write lane arrays into buf[cnt[3:0]]; bfly00_valid=0 on the next cycle.
- CALC, din_valid=1:
  - Read buf[cnt[3:0]], i.e. the beat from exactly DEPTH valid beats earlier.
  - Next cycle: bfly00_valid=1 with registered sum/diff for all 16 lanes.
  - Latency: 1 clock from input beat to result.
- din_valid=0 (any state): counter holds, nothing is written, bfly00_valid=0 on the next cycle, result outputs hold their last value. Gaps of any length anywhere in a block are legal and do not corrupt pairing.
- Arithmetic: sign-extend both operands to WIDTH+1 before add/sub. No saturation and no rounding; WIDTH+1 bits cannot overflow for WIDTH-bit inputs.
  - Example: (-256) - (+255) = -511 fits in 10 bits.
- Output cadence: exactly DEPTH valid result beats per block. The downstream twiddle counter relies on this (first 8 beats W=1, last 8 beats W=-j), so the block never emits a partial count except when interrupted by reset.
- Reset mid-block: the partial block is discarded, the counter returns to 0, bfly00_valid drops the cycle after reset, and the next valid beat is treated as beat 0 of a new block.
- rstn=1 together with din_valid=1: reset wins; the beat is neither written nor counted.
- Buffer: DEPTH x 16 lanes x 2 x WIDTH bits. Registers or inferred RAM are both acceptable. Write and read happen in different phases, so there is no read/write collision.

Test Plan:
- Ramp block: beat b lanes re = b*16+j-256, im = 0, 32 contiguous beats -> 16 valid beats starting one cycle after beat 16. Lane j of result beat k: sum_re = 2*(k*16+j)-256, diff_re = -256 for every lane; bfly00_valid high for exactly 16 cycles.
- Extremes: FILL beats re = im = -256 on all lanes, CALC beats re = im = +255 -> sum = -1, diff = -511 on every lane; outputs are 10-bit with no wrap.
- Gapped input: same ramp with din_valid toggling 1,0,1,0 -> identical 16 results to the contiguous case, each appearing one cycle after its CALC beat. Outputs hold during gaps; bfly00_valid=0 in gap cycles.
- Back-to-back: two blocks (second = first negated) with no idle cycle -> 32 total valid results; second block's results are the negation of the first's; o_fill returns high on the beat after beat 31.
- Reset mid-block: assert rstn after 20 beats, then send a full ramp block -> only 4 results before reset, none in the reset cycle, then exactly 16 correct ramp results.
- Reset during valid: rstn=1 and din_valid=1 together, then a full block -> counter = 0 after reset, the next beat lands in buf[0], results match the ramp case.
